// File: rtl/mbist_march_gen.sv
// March C- MBIST sequencer: drives address, data and strobes into the SRAM mux,
// compares returned read data and counts miscompares against the spare capacity.
module mbist_march_gen #(
  parameter int                      BIST_ADDR_WD    = 9,
  parameter int                      BIST_DATA_WD    = 32,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = '0,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END   = 9'h1F8,
  parameter int                      BIST_RD_LAT     = 1,
  parameter int                      BIST_REPAIR_CNT = 1,
  parameter int                      BIST_ERR_CNT_WD = 4
) (
  input  logic                       bist_clk,
  input  logic                       rst,
  input  logic                       bist_run,
  output logic                       bist_en,
  output logic [BIST_ADDR_WD-1:0]    bist_addr,
  output logic [BIST_DATA_WD-1:0]    bist_wdata,
  output logic                       bist_wr,
  output logic                       bist_rd,
  input  logic [BIST_DATA_WD-1:0]    bist_rdata,
  output logic                       bist_error,
  output logic [BIST_ADDR_WD-1:0]    bist_error_addr,
  output logic [BIST_ERR_CNT_WD-1:0] bist_err_cnt,
  output logic                       bist_done,
  output logic                       bist_fail,
  output logic [1:0]                 bist_state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                    state_q;
  logic                      run_prev_q;
  logic [2:0]                elem_q;
  logic [BIST_ADDR_WD-1:0]   addr_q;
  logic                      phase_q;
  logic                      en_q;
  logic                      wr_q;
  logic                      rd_q;
  logic                      exp_bit_q;
  logic                      done_q;
  logic [BIST_DATA_WD-1:0]   wdata_q;
  logic [1:0]                drain_cnt_q;

  logic                      start_w;
  logic                      abort_w;
  logic                      two_op_w;
  logic                      elem_end_w;
  logic                      last_op_w;
  logic [2:0]                elem_d;
  logic [BIST_ADDR_WD-1:0]   addr_d;
  logic                      phase_d;
  logic                      nxt_wr;
  logic                      nxt_bit;

  logic                      pipe_v_q    [BIST_RD_LAT];
  logic                      pipe_exp_q  [BIST_RD_LAT];
  logic [BIST_ADDR_WD-1:0]   pipe_addr_q [BIST_RD_LAT];
  logic                      err_q;
  logic [BIST_ADDR_WD-1:0]   err_addr_q;
  logic [BIST_ERR_CNT_WD-1:0] err_cnt_q;
  logic                      fail_q;
  logic                      miscmp_w;

  always_comb begin
    start_w    = (state_q == S_IDLE) && bist_run && !run_prev_q;
    abort_w    = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !bist_run;
    two_op_w   = (elem_q != 3'd0) && (elem_q != 3'd5);
    elem_end_w = (elem_q < 3'd3) ? (addr_q == BIST_ADDR_END) : (addr_q == BIST_ADDR_START);
    last_op_w  = (elem_q == 3'd5) && (addr_q == BIST_ADDR_START);
    elem_d     = elem_q;
    addr_d     = addr_q;
    phase_d    = 1'b0;
    if (two_op_w && !phase_q) begin
      phase_d = 1'b1;
    end else if (elem_end_w) begin
      elem_d = elem_q + 3'd1;
      addr_d = (elem_d < 3'd3) ? BIST_ADDR_START : BIST_ADDR_END;
    end else if (elem_q < 3'd3) begin
      addr_d = addr_q + BIST_ADDR_WD'(1);
    end else begin
      addr_d = addr_q - BIST_ADDR_WD'(1);
    end
    // Writes are M0 and the second op of M1..M4; M1/M3 write 1, M2/M4 read 1.
    nxt_wr  = (elem_d == 3'd0) || phase_d;
    nxt_bit = nxt_wr ? ((elem_d == 3'd1) || (elem_d == 3'd3))
                     : ((elem_d == 3'd2) || (elem_d == 3'd4));
  end

  always_ff @(posedge bist_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      run_prev_q  <= 1'b0;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      en_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      exp_bit_q   <= 1'b0;
      done_q      <= 1'b0;
      wdata_q     <= '0;
      drain_cnt_q <= 2'd0;
    end else begin
      run_prev_q <= bist_run;
      case (state_q)
        S_IDLE: begin
          if (start_w) begin
            state_q   <= S_RUN;
            elem_q    <= 3'd0;
            addr_q    <= BIST_ADDR_START;
            phase_q   <= 1'b0;
            en_q      <= 1'b1;
            wr_q      <= 1'b1;
            rd_q      <= 1'b0;
            wdata_q   <= '0;
            exp_bit_q <= 1'b0;
            done_q    <= 1'b0;
          end
        end
        S_RUN, S_DRAIN: begin
          if (abort_w) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
          end else if (state_q == S_RUN) begin
            if (last_op_w) begin
              state_q     <= S_DRAIN;
              wr_q        <= 1'b0;
              rd_q        <= 1'b0;
              wdata_q     <= '0;
              addr_q      <= '0;
              drain_cnt_q <= 2'd0;
            end else begin
              elem_q    <= elem_d;
              addr_q    <= addr_d;
              phase_q   <= phase_d;
              wr_q      <= nxt_wr;
              rd_q      <= !nxt_wr;
              wdata_q   <= nxt_wr ? {BIST_DATA_WD{nxt_bit}} : '0;
              exp_bit_q <= nxt_bit;
            end
          end else if (drain_cnt_q == 2'(BIST_RD_LAT)) begin
            state_q <= S_DONE;
            en_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 2'd1;
          end
        end
        S_DONE: begin
          if (!bist_run) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Expected polarity and address ride alongside each read until its data returns.
  assign miscmp_w = pipe_v_q[BIST_RD_LAT-1] && !abort_w &&
                    (bist_rdata != {BIST_DATA_WD{pipe_exp_q[BIST_RD_LAT-1]}});

  always_ff @(posedge bist_clk) begin
    if (rst) begin
      for (int i = 0; i < BIST_RD_LAT; i++) begin
        pipe_v_q[i]    <= 1'b0;
        pipe_exp_q[i]  <= 1'b0;
        pipe_addr_q[i] <= '0;
      end
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
      fail_q     <= 1'b0;
    end else begin
      pipe_v_q[0]    <= rd_q && !abort_w;
      pipe_exp_q[0]  <= exp_bit_q;
      pipe_addr_q[0] <= addr_q;
      for (int i = 1; i < BIST_RD_LAT; i++) begin
        pipe_v_q[i]    <= pipe_v_q[i-1] && !abort_w;
        pipe_exp_q[i]  <= pipe_exp_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
      err_q <= miscmp_w;
      if (miscmp_w) begin
        err_addr_q <= pipe_addr_q[BIST_RD_LAT-1];
      end
      if (start_w) begin
        err_cnt_q <= '0;
      end else if (miscmp_w && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + BIST_ERR_CNT_WD'(1);
      end
      fail_q <= !start_w && (32'(err_cnt_q) > BIST_REPAIR_CNT);
    end
  end

  assign bist_en         = en_q;
  assign bist_addr       = addr_q;
  assign bist_wdata      = wdata_q;
  assign bist_wr         = wr_q;
  assign bist_rd         = rd_q;
  assign bist_error      = err_q;
  assign bist_error_addr = err_addr_q;
  assign bist_err_cnt    = err_cnt_q;
  assign bist_done       = done_q;
  assign bist_fail       = fail_q;
  assign bist_state_dbg  = state_q;

endmodule
